// File: rtl/sm_fixed_pkg.sv
// Shared helpers for the sign-magnitude fixed-point multiplier: derived widths,
// rounding constant and sign-magnitude packing, all evaluated per instance.
package sm_fixed_pkg;

  // Widest word the generic helpers can handle; callers cast down to WIDTH.
  localparam int SM_MAX_W = 64;

  function automatic int sm_mag_w(input int width);
    return width - 1;
  endfunction

  function automatic int sm_prod_w(input int width);
    return 2 * (width - 1);
  endfunction

  function automatic logic [SM_MAX_W-1:0] sm_rnd_k(input int frac);
    return SM_MAX_W'(1) << (frac - 1);
  endfunction

  // Bits below width-1 come from mag, bit width-1 is the sign, the rest are zero.
  function automatic logic [SM_MAX_W-1:0] sm_pack(input logic sign,
                                                  input logic [SM_MAX_W-1:0] mag,
                                                  input int width);
    logic [SM_MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < SM_MAX_W; i++) begin
      if (i < width - 1)
        res[i] = mag[i];
      else if (i == width - 1)
        res[i] = sign;
    end
    return res;
  endfunction

endpackage

// File: rtl/sm_round_sat.sv
// Combinational output stage: round half away from zero, range check, saturate
// or wrap (SM_FIXED_MULT_SAT_EN selects saturation), and zero normalisation.
module sm_round_sat
  import sm_fixed_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int FRAC   = 11,
  localparam int PROD_W = sm_prod_w(WIDTH)
) (
  input  logic              i_sign,
  input  logic [PROD_W-1:0] i_prod,
  output logic [WIDTH-1:0]  o_c,
  output logic              o_ovf
);

  localparam int MAG_W = sm_mag_w(WIDTH);
  // One spare bit keeps the rounding add carry-safe for any legal FRAC.
  localparam int SUM_W = PROD_W + 1;
  localparam int R_W   = SUM_W - FRAC;
  localparam logic [SUM_W-1:0] RND_K = SUM_W'(sm_rnd_k(FRAC));

  logic [SUM_W-1:0] w_sum;
  logic [R_W-1:0]   w_r;
  logic [MAG_W-1:0] w_mag;
  logic             w_sign;

  assign w_sum = SUM_W'(i_prod) + RND_K;
  assign w_r   = R_W'(w_sum >> FRAC);
  assign o_ovf = |w_r[R_W-1:MAG_W];

`ifdef SM_FIXED_MULT_SAT_EN
  assign w_mag = o_ovf ? {MAG_W{1'b1}} : w_r[MAG_W-1:0];
`else
  assign w_mag = w_r[MAG_W-1:0];
`endif

  assign w_sign = i_sign & (|w_mag);
  assign o_c    = WIDTH'(sm_pack(w_sign, SM_MAX_W'(w_mag), WIDTH));

endmodule

// File: rtl/sm_fixed_mult_pipe.sv
// Three-stage sign-magnitude fixed-point multiplier with a single stall enable.
// Overflow handling on out_c is selected by SM_FIXED_MULT_SAT_EN (saturate) or wrap.
module sm_fixed_mult_pipe
  import sm_fixed_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int MAG_W  = sm_mag_w(WIDTH);
  localparam int PROD_W = sm_prod_w(WIDTH);

  if (WIDTH < 4 || FRAC < 1 || FRAC > WIDTH - 2) begin : g_bad_param
    $error("sm_fixed_mult_pipe: illegal WIDTH/FRAC combination");
  end

  logic              r_v1, r_v2, r_v3;
  logic              r_s1, r_s2;
  logic [MAG_W-1:0]  r_ma1, r_mb1;
  logic [PROD_W-1:0] r_p2;
  logic [WIDTH-1:0]  r_c3;
  logic              r_ovf3;
  logic              r_sticky;

  logic              w_adv;
  logic [WIDTH-1:0]  w_c;
  logic              w_ovf;

  // Whole pipe moves together; bubbles are held rather than collapsed.
  assign w_adv    = !r_v3 | out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1  <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
      r_ma1 <= in_a[MAG_W-1:0];
      r_mb1 <= in_b[MAG_W-1:0];
      r_s2  <= r_s1;
      r_p2  <= PROD_W'(r_ma1) * PROD_W'(r_mb1);
    end
  end

  sm_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_round_sat (
    .i_sign (r_s2),
    .i_prod (r_p2),
    .o_c    (w_c),
    .o_ovf  (w_ovf)
  );

  // Output register is reset so out_c reads zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c3   <= '0;
      r_ovf3 <= 1'b0;
    end else if (w_adv) begin
      r_c3   <= w_c;
      r_ovf3 <= w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_sticky <= 1'b0;
    else if (r_v3 & out_ready & r_ovf3)
      r_sticky <= 1'b1;
    else if (ovf_clr)
      r_sticky <= 1'b0;
  end

  assign out_valid  = r_v3;
  assign out_c      = r_c3;
  assign out_ovf    = r_ovf3;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_sm_fixed_mult_pipe.sv
// Directed bench for sm_fixed_mult_pipe (WIDTH=16, FRAC=11): vector table,
// backpressure stream, reset flush and sticky-flag corner cases.
module tb_sm_fixed_mult_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_ovf, ovf_sticky, ovf_clr;
  logic [15:0] in_a, in_b, out_c;

  always #5 clk = ~clk;

  sm_fixed_mult_pipe #(.WIDTH(16), .FRAC(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] c;
    logic        ovf;
    int          t;
  } exp_t;

  vec_t        vecs[15];
  exp_t        q[$];
  exp_t        m_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_recv  = 0;
  int          n_snap;
  logic        lat_chk = 1'b1;
  logic [15:0] cur_c   = '0;
  logic        cur_ovf = 1'b0;
  logic        hold_v  = 1'b0;
  logic [15:0] hold_c;
  logic        hold_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: records accepted pairs, checks every delivered result in order.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", out_valid, 1);
        check("stall_c", out_c, hold_c);
        check("stall_ovf", out_ovf, hold_ovf);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got result 0x%0h, expected none (cycle %0d)", out_c, cyc);
        end else begin
          m_e = q.pop_front();
          check("out_c", out_c, m_e.c);
          check("out_ovf", out_ovf, m_e.ovf);
          if (lat_chk) check("latency", cyc - m_e.t, 3);
          n_recv++;
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_c   = out_c;
      hold_ovf = out_ovf;
      if (in_valid && in_ready) q.push_back('{cur_c, cur_ovf, cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic ovf);
    logic acc;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    cur_c    = c;
    cur_ovf  = ovf;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (q.size() == 0) return;
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d results outstanding, expected 0", q.size());
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h0800, 16'h0800, 16'h0800, 1'b0};
    vecs[1]  = '{16'h8C00, 16'h1000, 16'h9800, 1'b0};
    vecs[2]  = '{16'h0001, 16'h0400, 16'h0001, 1'b0};
    vecs[3]  = '{16'h0001, 16'h03FF, 16'h0000, 1'b0};
    vecs[4]  = '{16'h8001, 16'h0400, 16'h8001, 1'b0};
    vecs[5]  = '{16'h0C00, 16'h0C00, 16'h1200, 1'b0};
    vecs[6]  = '{16'h8800, 16'h8800, 16'h0800, 1'b0};
    vecs[7]  = '{16'h7FFF, 16'h0800, 16'h7FFF, 1'b0};
    vecs[8]  = '{16'h8000, 16'h0800, 16'h0000, 1'b0};
    vecs[9]  = '{16'h8001, 16'h0001, 16'h0000, 1'b0};
`ifdef SM_FIXED_MULT_SAT_EN
    vecs[10] = '{16'h4000, 16'h2000, 16'h7FFF, 1'b1};
    vecs[11] = '{16'hC000, 16'h2000, 16'hFFFF, 1'b1};
    vecs[12] = '{16'h4000, 16'h1000, 16'h7FFF, 1'b1};
    vecs[13] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
`else
    vecs[10] = '{16'h4000, 16'h2000, 16'h0000, 1'b1};
    vecs[11] = '{16'hC000, 16'h2000, 16'h0000, 1'b1};
    vecs[12] = '{16'h4000, 16'h1000, 16'h0000, 1'b1};
    vecs[13] = '{16'h7FFF, 16'h7FFF, 16'h7FFF & 16'h7FE0, 1'b1};
`endif
    vecs[14] = '{16'hFFFF, 16'h0800, 16'hFFFF, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_out_c", out_c, 0);
    check("rst_in_ready", in_ready, 1);

    // Non-overflow vectors back to back; sticky must stay clear.
    for (int i = 0; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ovf);
    in_valid = 1'b0;
    drain();
    check("sticky_no_ovf", ovf_sticky, 0);

    for (int i = 10; i < 15; i++) send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ovf);
    in_valid = 1'b0;
    drain();
    check("sticky_after_ovf", ovf_sticky, 1);
    check("recv_table", n_recv, 15);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("sticky_cleared", ovf_sticky, 0);

    // Clear and overflow handshake in the same cycle: set must win.
    send(16'h4000, 16'h2000, vecs[10].c, 1'b1);
    in_valid = 1'b0;
    begin : wait_ovf
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid) disable wait_ovf;
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_ovf_timeout: got out_valid=0, expected a result");
    end
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("sticky_set_wins", ovf_sticky, 1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("sticky_clear2", ovf_sticky, 0);

    // Backpressure: 10 incrementing pairs, consumer stalls cycles 4..8.
    lat_chk = 1'b0;
    n_snap  = n_recv;
    fork
      begin
        for (int i = 1; i <= 10; i++) send(16'h0800, 16'(i), 16'(i), 1'b0);
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 20; t++) begin
          if (t == 4) out_ready = 1'b0;
          if (t == 9) out_ready = 1'b1;
          if (t == 7) begin
            @(negedge clk);
            check("inflight_count", q.size(), 3);
            check("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
          end else begin
            tick();
          end
        end
      end
    join
    drain();
    check("bp_recv_count", n_recv - n_snap, 10);

    // Reset with three items in flight: nothing may emerge afterwards.
    lat_chk   = 1'b1;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(16'h0800, 16'(i), 16'(i), 1'b0);
    in_valid = 1'b0;
    check("pre_rst_inflight", q.size(), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_c", out_c, 0);
    out_ready = 1'b1;
    n_snap    = n_recv;
    repeat (8) tick();
    check("no_stale_results", n_recv - n_snap, 0);
    check("post_rst_idle", out_valid, 0);

    send(16'h8C00, 16'h1000, 16'h9800, 1'b0);
    in_valid = 1'b0;
    drain();
    check("post_rst_recv", n_recv - n_snap, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
